// File: rtl/code_lock_seq.sv
// Clocked code lock: synchronised switch/key inputs, timed open window,
// consecutive-failure counter with timed alarm lockout. LEDs are active-low.
module code_lock_seq #(
  parameter int                CODE_W      = 4,
  parameter logic [CODE_W-1:0] CODE        = {CODE_W{1'b1}},
  parameter int                MAX_TRIES   = 3,
  parameter int                OPEN_CYC    = 8,
  parameter int                LOCKOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CODE_W-1:0]              sw,
  input  logic                           k,
  output logic                           led_open_n,
  output logic                           led_alarm_n,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int TW      = $clog2(MAX_TRIES + 1);
  localparam int MAX_CYC = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TMW     = $clog2(MAX_CYC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OPEN  = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;

  localparam logic [TW-1:0]  TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [TW-1:0]  LAST_TRY  = TW'(MAX_TRIES - 1);
  localparam logic [TMW-1:0] OPEN_T    = TMW'(OPEN_CYC);
  localparam logic [TMW-1:0] LOCK_T    = TMW'(LOCKOUT_CYC);
  localparam logic [TMW-1:0] T_ONE     = TMW'(1);

  logic              k_m, k_s, k_d;
  logic [CODE_W-1:0] sw_m, sw_s;
  logic [1:0]        fill;
  logic              armed;
  logic              press;
  logic              match;

  logic [1:0]        state;
  logic [TMW-1:0]    timer;
  logic [TW-1:0]     fail_cnt;

  // Presses are only armed once the synchroniser holds real samples and the key
  // has been seen released, so a key held through reset never fires on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_m   <= 1'b1;
      k_s   <= 1'b1;
      k_d   <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      k_m  <= k;
      k_s  <= k_m;
      k_d  <= k_s;
      sw_m <= sw;
      sw_s <= sw_m;
      fill <= {fill[0], 1'b1};
      if (fill[1] && k_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign press = armed & k_d & ~k_s;
  assign match = (sw_s == CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            if (match) begin
              state    <= OPEN;
              timer    <= OPEN_T;
              fail_cnt <= '0;
            end else if (fail_cnt == LAST_TRY) begin
              state    <= ALARM;
              timer    <= LOCK_T;
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
            end
          end
        end
        OPEN, ALARM: begin
          timer <= timer - 1'b1;
          if (timer == T_ONE) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    led_open_n  = 1'b1;
    led_alarm_n = 1'b1;
    tries_left  = TRIES_MAX;
    case (state)
      IDLE:    tries_left = TRIES_MAX - fail_cnt;
      OPEN:    led_open_n = 1'b0;
      ALARM: begin
        led_alarm_n = 1'b0;
        tries_left  = '0;
      end
      default: tries_left = TRIES_MAX;
    endcase
  end

endmodule

// File: tb/tb_code_lock_seq.sv
// Self-checking bench for code_lock_seq: directed scenarios plus random presses,
// compared each cycle against an event-queue model of the lock.
module tb_code_lock_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       k;
  logic       led_open_n;
  logic       led_alarm_n;
  logic [1:0] tries_left;

  int n_cmp;
  int n_err;
  int edge_no;

  // Model: a press takes effect three edges after the key falls.
  typedef struct {
    int         due;
    logic [3:0] code;
  } ev_t;
  ev_t evq[$];
  int  m_open;
  int  m_alarm;
  int  m_fails;

  code_lock_seq #(
    .CODE_W(4), .CODE(4'hF), .MAX_TRIES(3), .OPEN_CYC(8), .LOCKOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .k(k),
    .led_open_n(led_open_n), .led_alarm_n(led_alarm_n), .tries_left(tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    logic       ev;
    logic [3:0] c;
    ev = 1'b0;
    c  = 4'h0;
    while (evq.size() > 0 && evq[0].due <= edge_no) begin
      if (evq[0].due == edge_no) begin
        ev = 1'b1;
        c  = evq[0].code;
      end
      void'(evq.pop_front());
    end
    if (m_open > 0) m_open--;
    else if (m_alarm > 0) m_alarm--;
    else if (ev) begin
      if (c == 4'hF) begin
        m_open  = 8;
        m_fails = 0;
      end else if (m_fails + 1 == 3) begin
        m_alarm = 16;
        m_fails = 0;
      end else begin
        m_fails++;
      end
    end
  endtask

  function automatic logic [3:0] exp_vec();
    logic [1:0] t;
    if (m_open > 0) t = 2'd3;
    else if (m_alarm > 0) t = 2'd0;
    else t = 2'(3 - m_fails);
    return {m_open == 0, m_alarm == 0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (rst_n) model_step();
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    sw = code;
    tick();
    k = 1'b0;
    evq.push_back('{edge_no + 3, sw});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    k = 1'b1;
    sw = 4'h0;
    #1;
    n_cmp++;
    if ({led_open_n, led_alarm_n, tries_left} !== 4'b1111) begin
      n_err++;
      $display("[TB] FAIL reset_value: got %b want 1111", {led_open_n, led_alarm_n, tries_left});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== 4'b1111) begin
        n_err++;
        $display("[TB] FAIL reset_idle: cycle %0d got %b want 1111", i, {led_open_n, led_alarm_n, tries_left});
      end
    end
  endtask

  task automatic test_open();
    int open_cycles;
    open_cycles = 0;
    applyStimulus(4'hF);
    for (int i = 0; i < 14; i++) begin
      if (i == 2) k = 1'b1;
      tick();
      if (!led_open_n) open_cycles++;
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
        n_err++;
        $display("[TB] FAIL open: cycle %0d got %b want %b", i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
      end
    end
    n_cmp++;
    if (open_cycles !== 8) begin
      n_err++;
      $display("[TB] FAIL open_length: got %0d want 8", open_cycles);
    end
  endtask

  task automatic test_lockout();
    int alarm_cycles;
    alarm_cycles = 0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'h7);
      for (int i = 0; i < 6; i++) begin
        if (i == 2) k = 1'b1;
        tick();
        if (!led_alarm_n) alarm_cycles++;
        n_cmp++;
        if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
          n_err++;
          $display("[TB] FAIL lockout_press: press %0d cycle %0d got %b want %b", p, i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!led_alarm_n) alarm_cycles++;
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
        n_err++;
        $display("[TB] FAIL lockout_hold: cycle %0d got %b want %b", i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
      end
    end
    n_cmp++;
    if (alarm_cycles !== 16 || tries_left !== 2'd3) begin
      n_err++;
      $display("[TB] FAIL lockout_length: got %0d cycles tries %0d want 16 cycles tries 3", alarm_cycles, tries_left);
    end
  endtask

  task automatic test_history_clear();
    logic [3:0] codes [4];
    codes = '{4'h7, 4'h3, 4'hF, 4'h1};
    for (int p = 0; p < 4; p++) begin
      applyStimulus(codes[p]);
      for (int i = 0; i < 12; i++) begin
        if (i == 2) k = 1'b1;
        tick();
        n_cmp++;
        if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
          n_err++;
          $display("[TB] FAIL history: press %0d cycle %0d got %b want %b", p, i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
        end
      end
    end
    n_cmp++;
    if (tries_left !== 2'd2) begin
      n_err++;
      $display("[TB] FAIL history_cleared: got %0d want 2", tries_left);
    end
  endtask

  task automatic test_back_to_back();
    int fall_at [2];
    logic [1:0] want [2];
    int base;
    int rel;
    fall_at = '{8, 9};
    want    = '{2'd3, 2'd2};
    for (int s = 0; s < 2; s++) begin
      sw = 4'hF;
      repeat (3) tick();
      applyStimulus(4'hF);
      base = edge_no;
      for (int i = 0; i < 20; i++) begin
        rel = edge_no - base;
        if (rel == 2) k = 1'b1;
        if (rel == 5) sw = 4'h7;
        if (rel == fall_at[s]) begin
          k = 1'b0;
          evq.push_back('{edge_no + 3, sw});
        end
        if (rel == fall_at[s] + 2) k = 1'b1;
        tick();
        n_cmp++;
        if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
          n_err++;
          $display("[TB] FAIL back_to_back: case %0d cycle %0d got %b want %b", s, i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
        end
      end
      n_cmp++;
      if (tries_left !== want[s]) begin
        n_err++;
        $display("[TB] FAIL exit_edge_press: case %0d got %0d want %0d", s, tries_left, want[s]);
      end
    end
  endtask

  task automatic test_held_key();
    logic [3:0] codes [6];
    int holds [6];
    codes = '{4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'h7};
    holds = '{2, 50, 2, 2, 2, 2};
    for (int p = 0; p < 6; p++) begin
      applyStimulus(codes[p]);
      for (int i = 0; i < holds[p] + 4; i++) begin
        if (i == holds[p]) k = 1'b1;
        tick();
        n_cmp++;
        if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
          n_err++;
          $display("[TB] FAIL held_key: press %0d cycle %0d got %b want %b", p, i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
        end
      end
      if (p == 0) repeat (8) tick();
      if (p == 1) begin
        n_cmp++;
        if (tries_left !== 2'd2) begin
          n_err++;
          $display("[TB] FAIL held_single_fail: got %0d want 2", tries_left);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
        n_err++;
        $display("[TB] FAIL alarm_ignore: cycle %0d got %b want %b", i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
      end
    end
    n_cmp++;
    if ({led_open_n, led_alarm_n, tries_left} !== 4'b1111) begin
      n_err++;
      $display("[TB] FAIL after_alarm: got %b want 1111", {led_open_n, led_alarm_n, tries_left});
    end
    applyStimulus(4'hF);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) k = 1'b1;
      if (i == 5) sw = 4'h7;
      if (i == 7) begin
        k = 1'b0;
        evq.push_back('{edge_no + 3, sw});
      end
      if (i == 9) k = 1'b1;
      tick();
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
        n_err++;
        $display("[TB] FAIL open_ignore: cycle %0d got %b want %b", i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
      end
    end
    n_cmp++;
    if (tries_left !== 2'd3) begin
      n_err++;
      $display("[TB] FAIL open_press_counted: got %0d want 3", tries_left);
    end
  endtask

  task automatic test_reset_mid_open();
    applyStimulus(4'hF);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    m_open = 0;
    m_alarm = 0;
    m_fails = 0;
    evq.delete();
    n_cmp++;
    if ({led_open_n, led_alarm_n, tries_left} !== 4'b1111) begin
      n_err++;
      $display("[TB] FAIL async_reset: got %b want 1111", {led_open_n, led_alarm_n, tries_left});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== 4'b1111) begin
        n_err++;
        $display("[TB] FAIL held_through_reset: cycle %0d got %b want 1111", i, {led_open_n, led_alarm_n, tries_left});
      end
    end
    k = 1'b1;
    repeat (3) tick();
    applyStimulus(4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) k = 1'b1;
      tick();
      n_cmp++;
      if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
        n_err++;
        $display("[TB] FAIL repress_after_reset: cycle %0d got %b want %b", i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
      end
    end
    repeat (8) tick();
  endtask

  task automatic test_random();
    logic [3:0] code;
    int hold;
    int tail;
    for (int p = 0; p < 40; p++) begin
      code = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      hold = $urandom_range(1, 4);
      tail = $urandom_range(2, 15);
      applyStimulus(code);
      for (int i = 0; i < hold + tail; i++) begin
        if (i == hold) k = 1'b1;
        tick();
        n_cmp++;
        if ({led_open_n, led_alarm_n, tries_left} !== exp_vec()) begin
          n_err++;
          $display("[TB] FAIL random: press %0d code %h cycle %0d got %b want %b", p, code, i, {led_open_n, led_alarm_n, tries_left}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    edge_no = 0;
    m_open = 0;
    m_alarm = 0;
    m_fails = 0;
    test_reset();
    test_open();
    test_lockout();
    test_history_clear();
    test_back_to_back();
    test_held_key();
    test_reset_mid_open();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
